// File: rtl/mac_kbd_pkg.sv
// Shared constants and types for the Macintosh Plus keyboard emulation.
package mac_kbd_pkg;

    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;

    localparam logic [7:0] RSP_NULL   = 8'h7B;
    localparam logic [7:0] RSP_ACK    = 8'h7D;
    localparam logic [7:0] RSP_MODEL  = 8'h0B;
    localparam logic [7:0] RSP_PREFIX = 8'h79;

    localparam logic [6:0] MAP_CAPS = 7'h73;

    typedef struct packed {
        logic       keypad;
        logic [7:0] code;
    } kbd_evt_t;

    typedef enum logic {
        INQ_IDLE,
        INQ_WAIT
    } inq_state_t;

endpackage

// File: rtl/ps2_kbd_map.sv
// Set-2 scancode to M0110A key-code ROM; entry bit 7 flags keys sent behind the 0x79 prefix.
module ps2_kbd_map (
    input  logic       ext,
    input  logic [7:0] scancode,
    output logic       valid,
    output logic       keypad,
    output logic [6:0] mapcode
);
    logic [7:0] e;

    // Every Mac code is odd, so a zero entry doubles as "unmapped".
    always_comb begin
        e = 8'h00;
        case ({ext, scancode})
            9'h01C: e = 8'h01;  9'h01B: e = 8'h03;  9'h023: e = 8'h05;  9'h02B: e = 8'h07;
            9'h033: e = 8'h09;  9'h034: e = 8'h0B;  9'h01A: e = 8'h0D;  9'h022: e = 8'h0F;
            9'h021: e = 8'h11;  9'h02A: e = 8'h13;  9'h032: e = 8'h17;  9'h015: e = 8'h19;
            9'h01D: e = 8'h1B;  9'h024: e = 8'h1D;  9'h02D: e = 8'h1F;  9'h035: e = 8'h21;
            9'h02C: e = 8'h23;  9'h016: e = 8'h25;  9'h01E: e = 8'h27;  9'h026: e = 8'h29;
            9'h025: e = 8'h2B;  9'h036: e = 8'h2D;  9'h02E: e = 8'h2F;  9'h055: e = 8'h31;
            9'h046: e = 8'h33;  9'h03D: e = 8'h35;  9'h04E: e = 8'h37;  9'h03E: e = 8'h39;
            9'h045: e = 8'h3B;  9'h05B: e = 8'h3D;  9'h044: e = 8'h3F;  9'h03C: e = 8'h41;
            9'h054: e = 8'h43;  9'h043: e = 8'h45;  9'h04D: e = 8'h47;  9'h05A: e = 8'h49;
            9'h04B: e = 8'h4B;  9'h03B: e = 8'h4D;  9'h052: e = 8'h4F;  9'h042: e = 8'h51;
            9'h04C: e = 8'h53;  9'h05D: e = 8'h55;  9'h041: e = 8'h57;  9'h04A: e = 8'h59;
            9'h031: e = 8'h5B;  9'h03A: e = 8'h5D;  9'h049: e = 8'h5F;  9'h00D: e = 8'h61;
            9'h029: e = 8'h63;  9'h00E: e = 8'h65;  9'h066: e = 8'h67;  9'h014: e = 8'h6F;
            9'h11F: e = 8'h6F;  9'h012: e = 8'h71;  9'h059: e = 8'h71;  9'h058: e = 8'h73;
            9'h011: e = 8'h75;  9'h111: e = 8'h75;
            9'h070: e = 8'hA5;  9'h069: e = 8'hA7;  9'h072: e = 8'hA9;  9'h07A: e = 8'hAB;
            9'h06B: e = 8'hAD;  9'h073: e = 8'hAF;  9'h074: e = 8'hB1;  9'h06C: e = 8'hB3;
            9'h075: e = 8'hB7;  9'h07D: e = 8'hB9;  9'h071: e = 8'h83;  9'h07B: e = 8'h9D;
            9'h079: e = 8'h8D;  9'h07C: e = 8'h85;  9'h077: e = 8'h8F;  9'h14A: e = 8'h9B;
            9'h15A: e = 8'h99;
            // Arrows reuse the keypad operator codes, as on the M0110A.
            9'h175: e = 8'h9B;  9'h172: e = 8'h91;  9'h16B: e = 8'h8D;  9'h174: e = 8'h85;
            default: e = 8'h00;
        endcase
    end

    assign valid   = e[0];
    assign keypad  = e[7];
    assign mapcode = e[6:0];

endmodule

// File: rtl/ps2_kbd.sv
// M0110A keyboard emulation: PS/2 key events into a transition FIFO, answered
// one byte at a time to Inquiry/Instant/Model/Test commands from the Mac.
module ps2_kbd
    import mac_kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned INQUIRY_TIMEOUT = 2031250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  data_out,
    input  logic        strobe_out,
    output logic [7:0]  data_in,
    output logic        strobe_in,
    output logic        capslock
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(INQUIRY_TIMEOUT + 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(INQUIRY_TIMEOUT - 1);

    logic          m_valid, m_keypad;
    logic [6:0]    m_code;

    logic          prev_q, prev_d, caps_q, caps_d, strobe_q, strobe_d, prefix_q, prefix_d;
    logic [7:0]    data_q, data_d;
    inq_state_t    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    kbd_evt_t      mem_q [FIFO_DEPTH];
    kbd_evt_t      evt, head;
    logic          push_req, push, pop, send_head;

    ps2_kbd_map u_map (
        .ext      (ps2_key[8]),
        .scancode (ps2_key[7:0]),
        .valid    (m_valid),
        .keypad   (m_keypad),
        .mapcode  (m_code)
    );

    assign head = mem_q[rd_q];

    always_comb begin
        prev_d    = prev_q;
        caps_d    = caps_q;
        data_d    = data_q;
        strobe_d  = strobe_q;
        prefix_d  = prefix_q;
        state_d   = state_q;
        timer_d   = timer_q;
        evt       = '0;
        push_req  = 1'b0;
        send_head = 1'b0;
        pop       = 1'b0;
        push      = 1'b0;
        if (ce) begin
            prev_d   = ps2_key[10];
            strobe_d = 1'b0;
            if ((ps2_key[10] != prev_q) && m_valid) begin
                if (!m_keypad && m_code == MAP_CAPS) begin
                    if (ps2_key[9]) begin
                        caps_d   = ~caps_q;
                        evt      = '{keypad: 1'b0, code: {caps_q, MAP_CAPS}};
                        push_req = 1'b1;
                    end
                end else begin
                    evt      = '{keypad: m_keypad, code: {~ps2_key[9], m_code}};
                    push_req = 1'b1;
                end
            end
            if (strobe_out) begin
                state_d = INQ_IDLE;
                case (data_out)
                    CMD_INQUIRY: begin
                        if (cnt_q != '0) begin
                            send_head = 1'b1;
                        end else begin
                            state_d = INQ_WAIT;
                            timer_d = TW'(1);
                        end
                    end
                    CMD_INSTANT: begin
                        if (cnt_q != '0) begin
                            send_head = 1'b1;
                        end else begin
                            data_d   = RSP_NULL;
                            strobe_d = 1'b1;
                        end
                    end
                    CMD_MODEL: begin data_d = RSP_MODEL; strobe_d = 1'b1; end
                    CMD_TEST:  begin data_d = RSP_ACK;   strobe_d = 1'b1; end
                    default: ;
                endcase
            end else if (state_q == INQ_WAIT) begin
                // Pending Inquiry implies an empty FIFO, so the new event is the head.
                if (push_req) begin
                    state_d  = INQ_IDLE;
                    strobe_d = 1'b1;
                    if (evt.keypad) begin
                        data_d   = RSP_PREFIX;
                        prefix_d = 1'b1;
                    end else begin
                        data_d   = evt.code;
                        push_req = 1'b0;
                    end
                end else if (timer_q == TMO_LAST) begin
                    state_d  = INQ_IDLE;
                    data_d   = RSP_NULL;
                    strobe_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            if (send_head) begin
                strobe_d = 1'b1;
                if (head.keypad && !prefix_q) begin
                    data_d   = RSP_PREFIX;
                    prefix_d = 1'b1;
                end else begin
                    data_d   = head.code;
                    prefix_d = 1'b0;
                    pop      = 1'b1;
                end
            end
            push = push_req && (cnt_q != DEPTH_C);
        end
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= ps2_key[10];
            caps_q   <= 1'b0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            prefix_q <= 1'b0;
            state_q  <= INQ_IDLE;
            timer_q  <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            prev_q   <= prev_d;
            caps_q   <= caps_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            prefix_q <= prefix_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= evt;
        end
    end

    assign data_in   = data_q;
    assign strobe_in = strobe_q;
    assign capslock  = caps_q;

endmodule

// File: tb/tb_ps2_kbd.sv
// Scoreboard bench for ps2_kbd: commands push expected bytes, a monitor pops on strobe_in.
module tb_ps2_kbd;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce;
    logic [10:0] ps2_key = '0;
    logic [7:0]  data_out = '0;
    logic        strobe_out = 1'b0;
    logic [7:0]  data_in;
    logic        strobe_in, capslock;

    int          ph = 0;
    int unsigned ce_cnt = 0;
    int          n_cmp = 0, n_fail = 0, n_strobe = 0;
    int unsigned last_tick = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_e;

    ps2_kbd #(.FIFO_DEPTH(8), .INQUIRY_TIMEOUT(100)) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .ps2_key    (ps2_key),
        .data_out   (data_out),
        .strobe_out (strobe_out),
        .data_in    (data_in),
        .strobe_in  (strobe_in),
        .capslock   (capslock)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ph <= (ph + 1) % 4;
        if (ce) ce_cnt <= ce_cnt + 1;
    end
    assign ce = (ph == 0);

    always @(negedge clk) begin
        if (ce && strobe_in) begin
            n_strobe++;
            last_tick = ce_cnt;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got %02h, no response expected", data_in);
            end else begin
                mon_e = exp_q.pop_front();
                if (data_in !== mon_e) begin
                    n_fail++;
                    $display("FAIL rsp: got %02h expected %02h", data_in, mon_e);
                end
            end
        end
    end

    task automatic at_ce();
        do @(negedge clk); while (!ce);
    endtask

    task automatic ticks(input int n);
        repeat (n) at_ce();
    endtask

    task automatic send_cmd(input logic [7:0] b, output int unsigned t);
        at_ce();
        data_out   = b;
        strobe_out = 1'b1;
        t          = ce_cnt;
        @(negedge clk);
        strobe_out = 1'b0;
    endtask

    task automatic key_now(input logic ext, input logic [7:0] sc, input logic pr);
        ps2_key = {~ps2_key[10], pr, ext, sc};
    endtask

    task automatic key(input logic ext, input logic [7:0] sc, input logic pr);
        at_ce();
        key_now(ext, sc, pr);
    endtask

    task automatic cmd_expect(input logic [7:0] b, input logic [7:0] e);
        int unsigned t;
        exp_q.push_back(e);
        send_cmd(b, t);
        ticks(3);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_lat(input int s0, input int unsigned t0, input int lat, input string nm);
        int n = 0;
        while (n_strobe == s0 && n < 300) begin
            at_ce();
            n++;
        end
        if (n_strobe == s0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got no response expected latency %0d", nm, lat);
        end else begin
            check(nm, int'(last_tick - t0), lat);
        end
    endtask

    initial begin
        int          s0;
        int unsigned t;
        logic [7:0]  fill_sc [9];
        logic [7:0]  fill_cd [9];
        fill_sc = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h1A, 8'h22, 8'h21};
        fill_cd = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h0B, 8'h09, 8'h0D, 8'h0F, 8'h11};

        ticks(3);
        check("reset_data_in", data_in, 8'h00);
        check("reset_strobe_in", strobe_in, 0);
        check("reset_capslock", capslock, 0);
        at_ce();
        reset = 1'b0;
        ticks(2);

        // Model with latency check, Test, unknown command
        s0 = n_strobe;
        exp_q.push_back(8'h0B);
        send_cmd(8'h16, t);
        wait_lat(s0, t, 1, "model_latency");
        ticks(2);
        cmd_expect(8'h36, 8'h7D);
        s0 = n_strobe;
        send_cmd(8'h42, t);
        ticks(5);
        check("unknown_cmd_no_strobe", n_strobe - s0, 0);

        cmd_expect(8'h14, 8'h7B);

        key(1'b0, 8'h1C, 1'b1);
        cmd_expect(8'h10, 8'h01);
        key(1'b0, 8'h1C, 1'b0);
        cmd_expect(8'h10, 8'h81);

        // Inquiry timeout
        s0 = n_strobe;
        exp_q.push_back(8'h7B);
        send_cmd(8'h10, t);
        wait_lat(s0, t, 100, "inquiry_timeout_latency");
        ticks(2);

        // Inquiry answered by a key press 50 ticks after the command
        s0 = n_strobe;
        exp_q.push_back(8'h03);
        send_cmd(8'h10, t);
        do at_ce(); while (ce_cnt < t + 50);
        key_now(1'b0, 8'h1B, 1'b1);
        wait_lat(s0, t, 51, "inquiry_key_latency");
        ticks(2);
        key(1'b0, 8'h1B, 1'b0);
        cmd_expect(8'h14, 8'h83);

        // Keypad 8 press and release, each behind the prefix
        key(1'b0, 8'h75, 1'b1);
        cmd_expect(8'h14, 8'h79);
        cmd_expect(8'h14, 8'h37);
        key(1'b0, 8'h75, 1'b0);
        cmd_expect(8'h14, 8'h79);
        cmd_expect(8'h14, 8'hB7);

        // Caps Lock press / release / press
        key(1'b0, 8'h58, 1'b1);
        ticks(1);
        check("caps_on", capslock, 1);
        key(1'b0, 8'h58, 1'b0);
        ticks(1);
        check("caps_release_ignored", capslock, 1);
        key(1'b0, 8'h58, 1'b1);
        ticks(1);
        check("caps_off", capslock, 0);
        cmd_expect(8'h14, 8'h73);
        cmd_expect(8'h14, 8'hF3);
        cmd_expect(8'h14, 8'h7B);

        // Nine presses into an eight-entry FIFO
        for (int i = 0; i < 9; i++) key(1'b0, fill_sc[i], 1'b1);
        for (int i = 0; i < 8; i++) cmd_expect(8'h14, fill_cd[i]);
        cmd_expect(8'h14, 8'h7B);

        // Reset while an Inquiry is pending
        s0 = n_strobe;
        send_cmd(8'h10, t);
        ticks(10);
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(120);
        check("reset_cancels_inquiry", n_strobe - s0, 0);
        check("post_reset_data_in", data_in, 8'h00);

        ticks(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
